fx_reverb_comb: RTL and testbench

- Parametrised multichannel successor to the stereo reverb FX slot (FX 7).
- Each channel runs one damped feedback comb filter (Freeverb-style) over a circular delay line in block RAM.
- Samples enter through a valid/ready handshake. Channels are processed time-multiplexed by an FSM, then the output is dry/wet mixed.
- Sits in the FX chain at the same slot and uses the same size/damping/mix controls.

---
 rtl/fx_pkg.sv | 24 ++
 rtl/fx_delay_ram.sv | 23 ++
 rtl/fx_reverb_comb.sv | 155 +++++++++++++++
 tb/tb_fx_reverb_comb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared types and arithmetic helpers for the multichannel comb reverb.
package fx_pkg;

    typedef enum logic [2:0] {CLEAR, IDLE, RD, CALC, OUT} state_t;

    localparam int Q_FULL  = 128;
    localparam int FB_BASE = Q_FULL / 2;
    localparam int ACC_W   = 48;

    // Clamp a wide signed value to the range of a w-bit signed sample.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W-1:0] v,
                                                      input int w);
        logic signed [ACC_W-1:0] one;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        one = ACC_W'(1);
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fx_delay_ram.sv
// Delay-line storage: one write port, one synchronous read port, no reset.
module fx_delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int WORDS  = 8192
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fx_reverb_comb.sv
// Time-multiplexed damped feedback comb filter per channel with dry/wet mix.
module fx_reverb_comb
    import fx_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int PARAM_W   = 7,
    parameter int N_CH      = 2,
    parameter int DLY_SHIFT = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_CH-1:0][DATA_W-1:0]   audio_in,
    output logic                          out_valid,
    output logic [N_CH-1:0][DATA_W-1:0]   audio_out,
    input  logic [PARAM_W-1:0]            size,
    input  logic [PARAM_W-1:0]            damping,
    input  logic [PARAM_W-1:0]            mix
);

    localparam int DEPTH_W = PARAM_W + DLY_SHIFT;
    localparam int DEPTH   = 1 << DEPTH_W;
    localparam int LEN_W   = DEPTH_W + 1;
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ADDR_W  = CH_W + DEPTH_W;
    localparam int WORDS   = N_CH * DEPTH;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(WORDS - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

    state_t                      state;
    logic [CH_W-1:0]             ch;
    logic [DEPTH_W-1:0]          wptr;
    logic [ADDR_W-1:0]           clr_cnt;
    logic signed [DATA_W-1:0]    filt [N_CH];
    logic [N_CH-1:0][DATA_W-1:0] x_lat;
    logic [N_CH-1:0][DATA_W-1:0] y_buf;
    logic [PARAM_W-1:0]          size_l;
    logic [PARAM_W-1:0]          damp_l;
    logic [PARAM_W-1:0]          mix_l;

    logic [LEN_W-1:0]            len_base;
    logic [LEN_W-1:0]            dly_len;
    logic [DEPTH_W-1:0]          rd_off;

    logic                        ram_we;
    logic                        ram_re;
    logic [ADDR_W-1:0]           ram_waddr;
    logic [ADDR_W-1:0]           ram_raddr;
    logic [DATA_W-1:0]           ram_wdata;
    logic [DATA_W-1:0]           ram_rdata;

    logic signed [ACC_W-1:0]     d_s, f_s, x_s, damp_s, mix_s, g_s;
    logic signed [ACC_W-1:0]     filt_new, fb_sat, y_sat;

    // A length of exactly DEPTH truncates to 0, so the read hits the word about to be overwritten.
    always_comb begin
        len_base = LEN_W'(size_l) + LEN_W'(1);
        dly_len  = len_base << DLY_SHIFT;
        rd_off   = wptr - dly_len[DEPTH_W-1:0];
    end

    assign ram_re    = (state == RD);
    assign ram_raddr = {ch, rd_off};
    assign ram_we    = !reset && ((state == CLEAR) || (state == CALC));
    assign ram_waddr = (state == CLEAR) ? clr_cnt : {ch, wptr};
    assign ram_wdata = (state == CLEAR) ? '0 : fb_sat[DATA_W-1:0];

    always_comb begin
        d_s      = ACC_W'($signed(ram_rdata));
        f_s      = ACC_W'(filt[ch]);
        x_s      = ACC_W'($signed(x_lat[ch]));
        damp_s   = ACC_W'(damp_l);
        mix_s    = ACC_W'(mix_l);
        g_s      = ACC_W'(FB_BASE) + ACC_W'(size_l >> 2);
        filt_new = d_s + (((f_s - d_s) * damp_s) >>> PARAM_W);
        fb_sat   = sat(x_s + ((filt_new * g_s) >>> PARAM_W), DATA_W);
        y_sat    = sat(x_s + (((d_s - x_s) * mix_s) >>> PARAM_W), DATA_W);
    end

    // filt_new always lies between d and the old state, so truncation is lossless.
    logic unused_bits;
    assign unused_bits = ^{dly_len[DEPTH_W], filt_new[ACC_W-1:DATA_W],
                           fb_sat[ACC_W-1:DATA_W], y_sat[ACC_W-1:DATA_W]};

    fx_delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            ch        <= '0;
            wptr      <= '0;
            clr_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            audio_out <= '0;
            for (int i = 0; i < N_CH; i++) filt[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        x_lat    <= audio_in;
                        size_l   <= size;
                        damp_l   <= damping;
                        mix_l    <= mix;
                        ch       <= '0;
                        in_ready <= 1'b0;
                        state    <= RD;
                    end
                end
                RD: state <= CALC;
                CALC: begin
                    filt[ch]  <= filt_new[DATA_W-1:0];
                    y_buf[ch] <= y_sat[DATA_W-1:0];
                    if (ch == CH_LAST) begin
                        state <= OUT;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= RD;
                    end
                end
                OUT: begin
                    audio_out <= y_buf;
                    out_valid <= 1'b1;
                    wptr      <= wptr + 1'b1;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_reverb_comb.sv
// Directed/randomized bench for fx_reverb_comb against a frame-history reference model.
module tb_fx_reverb_comb;

    localparam int DATA_W  = 16;
    localparam int PARAM_W = 7;
    localparam int N_CH    = 2;
    localparam int DEPTH   = 4096;
    localparam int HIST    = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        reset;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_CH-1:0][DATA_W-1:0] audio_in;
    logic                        out_valid;
    logic [N_CH-1:0][DATA_W-1:0] audio_out;
    logic [PARAM_W-1:0]          size;
    logic [PARAM_W-1:0]          damping;
    logic [PARAM_W-1:0]          mix;

    fx_reverb_comb #(
        .DATA_W    (DATA_W),
        .PARAM_W   (PARAM_W),
        .N_CH      (N_CH),
        .DLY_SHIFT (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .audio_in  (audio_in),
        .out_valid (out_valid),
        .audio_out (audio_out),
        .size      (size),
        .damping   (damping),
        .mix       (mix)
    );

    int errors = 0;
    int checks = 0;

    // Reference: every frame's delay-line write, indexed by absolute frame number since reset.
    int hist [N_CH][HIST];
    int filt_m [N_CH];
    int frame_m;
    int exp_y [N_CH];

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        frame_m = 0;
        for (int c = 0; c < N_CH; c++) filt_m[c] = 0;
    endtask

    task automatic model_step(input logic [N_CH-1:0][DATA_W-1:0] fr,
                              input int sz, input int dm, input int mx);
        for (int c = 0; c < N_CH; c++) begin
            int xi, len, d, fn, g;
            xi  = int'($signed(fr[c]));
            len = (sz + 1) * 32;
            d   = (frame_m >= len) ? hist[c][frame_m - len] : 0;
            fn  = d + (((filt_m[c] - d) * dm) >>> 7);
            filt_m[c] = fn;
            g   = 64 + sz / 4;
            hist[c][frame_m] = clamp16(xi + ((fn * g) >>> 7));
            exp_y[c] = clamp16(xi + (((d - xi) * mx) >>> 7));
        end
        frame_m++;
    endtask

    task automatic wait_clear();
        int n;
        bit ov;
        n  = 0;
        ov = 1'b0;
        while (!in_ready && n < 9000) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) ov = 1'b1;
        end
        chk("clear_cycles", n, N_CH * DEPTH);
        chk("clear_no_out_valid", int'(ov), 0);
    endtask

    task automatic send(input logic [N_CH-1:0][DATA_W-1:0] fr,
                        input int sz, input int dm, input int mx);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_send", int'(in_ready), 1);
        audio_in = fr;
        size     = PARAM_W'(sz);
        damping  = PARAM_W'(dm);
        mix      = PARAM_W'(mx);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble controls and data: the frame in flight must use the latched copies.
        audio_in = {DATA_W'($urandom), DATA_W'($urandom)};
        size     = PARAM_W'($urandom);
        damping  = PARAM_W'($urandom);
        mix      = PARAM_W'($urandom);
        model_step(fr, sz, dm, mx);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 5);
        for (int c = 0; c < N_CH; c++)
            chk($sformatf("out_ch%0d_frame%0d", c, frame_m - 1),
                int'($signed(audio_out[c])), exp_y[c]);
    endtask

    logic [N_CH-1:0][DATA_W-1:0] fr;
    int  last_acc, n_acc, n_out;
    bit  acc, ov;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        audio_in = '0;
        size     = '0;
        damping  = '0;
        mix      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_audio_out", int'(audio_out), 0);
        reset = 1'b0;
        wait_clear();
        model_reset();

        // Dry path: mix = 0 must reproduce the input exactly.
        for (int i = 0; i < 24; i++) begin
            fr = {DATA_W'($urandom), DATA_W'($urandom)};
            send(fr, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 0);
            for (int c = 0; c < N_CH; c++)
                chk("dry_exact", int'(audio_out[c]), int'(fr[c]));
        end

        // Random controls with short delays so echoes fall inside the run.
        for (int i = 0; i < 40; i++) begin
            fr = {DATA_W'($urandom), DATA_W'($urandom)};
            send(fr, int'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 127)));
        end

        // Undamped impulse echo.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear();
        model_reset();
        for (int i = 0; i < 70; i++) begin
            fr = '0;
            if (i == 0) fr[0] = DATA_W'(16384);
            send(fr, 0, 0, 127);
            if (i == 32) chk("impulse_f32", int'($signed(audio_out[0])), 16256);
            if (i == 64) chk("impulse_f64", int'($signed(audio_out[0])), 8128);
        end

        // Damped impulse echo.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear();
        model_reset();
        for (int i = 0; i < 70; i++) begin
            fr = '0;
            if (i == 0) fr[0] = DATA_W'(16384);
            send(fr, 0, 64, 127);
            if (i == 32) chk("damp_f32", int'($signed(audio_out[0])), 16256);
            if (i == 64) chk("damp_f64", int'($signed(audio_out[0])), 4064);
        end

        // Full-length delay, saturating feedback, write pointer wraps past 4095.
        fr = {DATA_W'(32767), DATA_W'(32767)};
        for (int i = 0; i < 5000; i++) begin
            send(fr, 127, 32, 127);
            for (int c = 0; c < N_CH; c++)
                chk("sat_nonneg", int'(audio_out[c][DATA_W-1]), 0);
        end
        chk("sat_final", int'($signed(audio_out[0])), 32767);

        // in_valid held high: accepts only from IDLE, one every 6 cycles.
        fr       = {DATA_W'(-2000), DATA_W'(1000)};
        audio_in = fr;
        size     = PARAM_W'(3);
        damping  = PARAM_W'(10);
        mix      = '0;
        in_valid = 1'b1;
        last_acc = -1;
        n_acc    = 0;
        n_out    = 0;
        for (int c = 0; c < 30; c++) begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (last_acc >= 0) chk("accept_gap", c - last_acc, 6);
                last_acc = c;
                n_acc++;
                model_step(fr, 3, 10, 0);
            end
            if (out_valid) begin
                n_out++;
                for (int k = 0; k < N_CH; k++)
                    chk("held_out", int'($signed(audio_out[k])), exp_y[k]);
            end
        end
        in_valid = 1'b0;
        chk("held_accepts", n_acc, 5);
        chk("held_outputs", n_out, 5);

        // Reset while the first channel is in CALC: frame is dropped, CLEAR restarts.
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        ov    = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) ov = 1'b1;
        end
        chk("midreset_no_out_valid", int'(ov), 0);
        chk("midreset_in_ready", int'(in_ready), 0);
        chk("midreset_audio_out", int'(audio_out), 0);
        reset = 1'b0;
        wait_clear();
        model_reset();
        fr = {DATA_W'($urandom), DATA_W'($urandom)};
        send(fr, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 127)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
